// File: rtl/cube_move_engine.sv
// cube_move_engine
//   Move-execution sequencer in front of the cube register file. It accepts
//   one face-turn command and reads the three colour planes. It applies the
//   turn one quarter turn per cycle as a 24-bit sticker permutation, then
//   writes the planes back. Finally it compares them with the ideal planes
//   to report whether the cube is solved.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake (accepted when both high at posedge)
//   cmd_face          0 = U face, 1 = R face
//   cmd_turns         clockwise quarter turns, 0..3
//   src0/src1         register file read addresses
//   data0/data1       register file read data (combinational from src0/src1)
//   dst/we/data       register file write port
//   busy              command in progress
//   done              one-cycle pulse when a command completes
//   solved            planes matched the ideal planes at the last completion
//   move_count        total quarter turns applied (wraps)
//
// Sticker bit i = 4*face + pos, with faces U=0 D=1 F=2 B=3 L=4 R=5 and
// pos 0=TL 1=TR 2=BR 3=BL seen head-on. The permutation indices below are
// hard-wired for that 24-sticker layout.

module cube_move_engine #(
  parameter int PLANE_W    = 24,
  parameter int REG_PLANE0 = 0,
  parameter int REG_IDEAL0 = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_face,
  input  logic [1:0]         cmd_turns,
  output logic [3:0]         src0,
  output logic [3:0]         src1,
  input  logic [PLANE_W-1:0] data0,
  input  logic [PLANE_W-1:0] data1,
  output logic [3:0]         dst,
  output logic               we,
  output logic [PLANE_W-1:0] data,
  output logic               busy,
  output logic               done,
  output logic               solved,
  output logic [15:0]        move_count
);

  localparam logic [3:0] PLANE0_A = 4'(REG_PLANE0);
  localparam logic [3:0] PLANE1_A = 4'(REG_PLANE0 + 1);
  localparam logic [3:0] PLANE2_A = 4'(REG_PLANE0 + 2);
  localparam logic [3:0] IDEAL0_A = 4'(REG_IDEAL0);
  localparam logic [3:0] IDEAL1_A = 4'(REG_IDEAL0 + 1);
  localparam logic [3:0] IDEAL2_A = 4'(REG_IDEAL0 + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_RD01, S_RD2, S_PERM, S_WR0, S_WR1, S_WR2, S_CK01, S_CK2, S_DONE
  } state_t;

  state_t             state, state_next;
  logic               face_q;
  logic [1:0]         turns_q;
  logic [PLANE_W-1:0] p0, p1, p2;
  logic               eq01, eq2;

  // One clockwise quarter turn of the selected face, applied to one plane.
  function automatic logic [PLANE_W-1:0] quarter_turn(input logic face,
                                                      input logic [PLANE_W-1:0] s);
    logic [PLANE_W-1:0] n;
    n = s;
    if (!face) begin
      // U face rotates in place.
      n[1]  = s[0];  n[2]  = s[1];  n[3]  = s[2];  n[0]  = s[3];
      // Top rows of the side faces: F -> L -> B -> R -> F.
      n[16] = s[8];  n[17] = s[9];
      n[12] = s[16]; n[13] = s[17];
      n[20] = s[12]; n[21] = s[13];
      n[8]  = s[20]; n[9]  = s[21];
    end else begin
      // R face rotates in place.
      n[21] = s[20]; n[22] = s[21]; n[23] = s[22]; n[20] = s[23];
      // Right column F -> U -> B -> D -> F. B is viewed from behind, so its
      // left column (pos 0/3) is the one adjacent to R, and it flips.
      n[1]  = s[9];  n[2]  = s[10];
      n[15] = s[1];  n[12] = s[2];
      n[6]  = s[15]; n[5]  = s[12];
      n[10] = s[5];  n[9]  = s[6];
    end
    return n;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic. PERM exits when the remaining-turn counter is on its
  // last turn, so PERM lasts exactly the requested number of cycles.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_next = S_RD01;
      S_RD01:  state_next = S_RD2;
      S_RD2:   state_next = (turns_q != 2'd0) ? S_PERM : S_WR0;
      S_PERM:  if (turns_q == 2'd1) state_next = S_WR0;
      S_WR0:   state_next = S_WR1;
      S_WR1:   state_next = S_WR2;
      S_WR2:   state_next = S_CK01;
      S_CK01:  state_next = S_CK2;
      S_CK2:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Register-file port and status outputs, decoded from state alone so that
  // an asynchronous reset drops the write enable immediately.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    src0      = '0;
    src1      = '0;
    dst       = '0;
    we        = 1'b0;
    data      = '0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_RD01: begin
        src0 = PLANE0_A;
        src1 = PLANE1_A;
      end
      S_RD2:  src0 = PLANE2_A;
      S_WR0: begin
        we   = 1'b1;
        dst  = PLANE0_A;
        data = p0;
      end
      S_WR1: begin
        we   = 1'b1;
        dst  = PLANE1_A;
        data = p1;
      end
      S_WR2: begin
        we   = 1'b1;
        dst  = PLANE2_A;
        data = p2;
      end
      S_CK01: begin
        src0 = IDEAL0_A;
        src1 = IDEAL1_A;
      end
      S_CK2:  src0 = IDEAL2_A;
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: command capture, plane buffers, permutation, comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      face_q     <= 1'b0;
      turns_q    <= 2'd0;
      p0         <= '0;
      p1         <= '0;
      p2         <= '0;
      eq01       <= 1'b0;
      eq2        <= 1'b0;
      solved     <= 1'b0;
      move_count <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            face_q  <= cmd_face;
            turns_q <= cmd_turns;
          end
        end
        S_RD01: begin
          p0 <= data0;
          p1 <= data1;
        end
        S_RD2:  p2 <= data0;
        S_PERM: begin
          p0         <= quarter_turn(face_q, p0);
          p1         <= quarter_turn(face_q, p1);
          p2         <= quarter_turn(face_q, p2);
          turns_q    <= turns_q - 2'd1;
          move_count <= move_count + 16'd1;
        end
        S_CK01: eq01   <= (p0 == data0) && (p1 == data1);
        S_CK2:  eq2    <= (p2 == data0);
        S_DONE: solved <= eq01 && eq2;
        default: ;
      endcase
    end
  end

endmodule
